ts_os_receiver: RTL and testbench

Per-lane receive-side ordered-set parser for the PIPE PHY model. It sits directly downstream of the lane's rx data path: it consumes the 8-bit symbol stream (rxdata/rxdatak/rxvalid/rxelecidle) that the PHY drives toward the MAC. It aligns on COM, validates 16-symbol TS1/TS2 ordered sets, exports the decoded training fields, and counts consecutive identical sets. The LTSSM uses these counts for Polling.Active → Polling.Configuration → Configuration exit decisions. One instance per lane.

---
 rtl/ts_os_receiver.sv | 231 +++++++++++++++++++++++
 tb/tb_ts_os_receiver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ts_os_receiver.sv
// Per-lane TS1/TS2 ordered-set receiver: aligns on COM, validates 16-symbol sets,
// exports the training fields and counts consecutive identical sets for the LTSSM.
module ts_os_receiver #(
  parameter int NTS   = 8,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rxdata,
  input  logic             rxdatak,
  input  logic             rxvalid,
  input  logic             rxelecidle,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic [7:0]       n_fts,
  output logic [7:0]       rate_id,
  output logic [7:0]       train_ctl,
  output logic             link_pad,
  output logic             lane_pad,
  output logic [CNT_W-1:0] ts1_cnt,
  output logic [CNT_W-1:0] ts2_cnt,
  output logic             ts1_done,
  output logic             ts2_done,
  output logic             os_err
);

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] PAD_SYM = 8'hF7;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] NTS_C   = CNT_W'(NTS);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t           r_state, w_state_nx;
  logic [3:0]       r_idx, w_idx_nx;

  // shadow copy of the set being collected; r_sh_type 1 = TS2
  logic [7:0]       r_sh_link, r_sh_lane, r_sh_nfts, r_sh_rate, r_sh_ctl;
  logic             r_sh_lpad, r_sh_npad, r_sh_type;

  logic [7:0]       r_link, r_lane, r_nfts, r_rate, r_ctl;
  logic             r_lpad, r_npad;
  logic             r_prev_vld, r_prev_type;
  logic [CNT_W-1:0] r_ts1_cnt, r_ts2_cnt;
  logic             r_ts1_done, r_ts2_done;
  logic             r_ts1_det, r_ts2_det, r_os_err;

  logic             w_com, w_pad, w_sym_ok, w_upd, w_good, w_err, w_same;
  logic [7:0]       w_id;
  logic [CNT_W-1:0] w_ts1_nx, w_ts2_nx;

  assign w_com = rxdatak && (rxdata == COM_SYM);
  assign w_pad = rxdatak && (rxdata == PAD_SYM);
  assign w_id  = r_sh_type ? TS2_ID : TS1_ID;

  always_comb begin
    w_sym_ok = 1'b0;
    unique case (r_idx)
      4'd1, 4'd2:       w_sym_ok = w_pad || !rxdatak;
      4'd3, 4'd4, 4'd5: w_sym_ok = !rxdatak;
      4'd6:             w_sym_ok = !rxdatak && (rxdata == TS1_ID || rxdata == TS2_ID);
      default:          w_sym_ok = !rxdatak && (rxdata == w_id);
    endcase
  end

  // next-state / event decode; electrical idle overrides any symbol
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_upd      = 1'b0;
    w_good     = 1'b0;
    w_err      = 1'b0;
    if (rxelecidle) begin
      w_state_nx = HUNT;
      w_idx_nx   = 4'd0;
    end else if (rxvalid) begin
      unique case (r_state)
        HUNT: begin
          if (w_com) begin
            w_state_nx = COLLECT;
            w_idx_nx   = 4'd1;
          end
        end
        COLLECT: begin
          if (w_sym_ok) begin
            w_upd = 1'b1;
            if (r_idx == 4'd15) begin
              w_good     = 1'b1;
              w_state_nx = HUNT;
              w_idx_nx   = 4'd0;
            end else begin
              w_idx_nx = r_idx + 4'd1;
            end
          end else begin
            w_err = 1'b1;
            if (w_com) begin
              w_state_nx = COLLECT;
              w_idx_nx   = 4'd1;
            end else begin
              w_state_nx = HUNT;
              w_idx_nx   = 4'd0;
            end
          end
        end
        default: begin
          w_state_nx = HUNT;
          w_idx_nx   = 4'd0;
        end
      endcase
    end
  end

  assign w_same = r_prev_vld && (r_prev_type == r_sh_type) &&
                  (r_sh_link == r_link) && (r_sh_lane == r_lane) &&
                  (r_sh_nfts == r_nfts) && (r_sh_rate == r_rate) &&
                  (r_sh_ctl == r_ctl) && (r_sh_lpad == r_lpad) &&
                  (r_sh_npad == r_npad);

  always_comb begin
    w_ts1_nx = r_ts1_cnt;
    w_ts2_nx = r_ts2_cnt;
    if (rxelecidle || w_err) begin
      w_ts1_nx = '0;
      w_ts2_nx = '0;
    end else if (w_good) begin
      if (r_sh_type) begin
        w_ts1_nx = '0;
        w_ts2_nx = !w_same ? CNT_W'(1) :
                   (r_ts2_cnt == CNT_MAX) ? r_ts2_cnt : r_ts2_cnt + 1'b1;
      end else begin
        w_ts2_nx = '0;
        w_ts1_nx = !w_same ? CNT_W'(1) :
                   (r_ts1_cnt == CNT_MAX) ? r_ts1_cnt : r_ts1_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HUNT;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_sh_link   <= '0;
      r_sh_lane   <= '0;
      r_sh_nfts   <= '0;
      r_sh_rate   <= '0;
      r_sh_ctl    <= '0;
      r_sh_lpad   <= 1'b0;
      r_sh_npad   <= 1'b0;
      r_sh_type   <= 1'b0;
    end else begin
      r_idx <= w_idx_nx;
      if (w_upd) begin
        unique case (r_idx)
          4'd1: begin r_sh_link <= rxdata; r_sh_lpad <= w_pad; end
          4'd2: begin r_sh_lane <= rxdata; r_sh_npad <= w_pad; end
          4'd3: r_sh_nfts <= rxdata;
          4'd4: r_sh_rate <= rxdata;
          4'd5: r_sh_ctl  <= rxdata;
          4'd6: r_sh_type <= (rxdata == TS2_ID);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_link      <= '0;
      r_lane      <= '0;
      r_nfts      <= '0;
      r_rate      <= '0;
      r_ctl       <= '0;
      r_lpad      <= 1'b0;
      r_npad      <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_prev_type <= 1'b0;
      r_ts1_cnt   <= '0;
      r_ts2_cnt   <= '0;
      r_ts1_done  <= 1'b0;
      r_ts2_done  <= 1'b0;
      r_ts1_det   <= 1'b0;
      r_ts2_det   <= 1'b0;
      r_os_err    <= 1'b0;
    end else begin
      r_ts1_cnt  <= w_ts1_nx;
      r_ts2_cnt  <= w_ts2_nx;
      r_ts1_done <= (w_ts1_nx >= NTS_C);
      r_ts2_done <= (w_ts2_nx >= NTS_C);
      r_ts1_det  <= w_good && !r_sh_type;
      r_ts2_det  <= w_good && r_sh_type;
      r_os_err   <= w_err;
      if (rxelecidle || w_err) begin
        r_prev_vld <= 1'b0;
      end else if (w_good) begin
        r_link      <= r_sh_link;
        r_lane      <= r_sh_lane;
        r_nfts      <= r_sh_nfts;
        r_rate      <= r_sh_rate;
        r_ctl       <= r_sh_ctl;
        r_lpad      <= r_sh_lpad;
        r_npad      <= r_sh_npad;
        r_prev_vld  <= 1'b1;
        r_prev_type <= r_sh_type;
      end
    end
  end

  assign ts1_det   = r_ts1_det;
  assign ts2_det   = r_ts2_det;
  assign os_err    = r_os_err;
  assign link_num  = r_link;
  assign lane_num  = r_lane;
  assign n_fts     = r_nfts;
  assign rate_id   = r_rate;
  assign train_ctl = r_ctl;
  assign link_pad  = r_lpad;
  assign lane_pad  = r_npad;
  assign ts1_cnt   = r_ts1_cnt;
  assign ts2_cnt   = r_ts2_cnt;
  assign ts1_done  = r_ts1_done;
  assign ts2_done  = r_ts2_done;

endmodule

// File: tb/tb_ts_os_receiver.sv
// Directed bench for ts_os_receiver: one task per scenario with inline expected values.
module tb_ts_os_receiver;
  localparam int NTS = 8, CNT_W = 11;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] rxdata = '0;
  logic rxdatak = 1'b0, rxvalid = 1'b0, rxelecidle = 1'b0;
  logic ts1_det, ts2_det, link_pad, lane_pad, ts1_done, ts2_done, os_err;
  logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctl;
  logic [CNT_W-1:0] ts1_cnt, ts2_cnt;

  int n_cmp = 0, n_bad = 0;
  int n_det1 = 0, n_det2 = 0, n_err = 0, n_both = 0;

  always #5 clk = ~clk;

  ts_os_receiver #(.NTS(NTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .rxdata(rxdata), .rxdatak(rxdatak),
    .rxvalid(rxvalid), .rxelecidle(rxelecidle), .ts1_det(ts1_det), .ts2_det(ts2_det),
    .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts), .rate_id(rate_id),
    .train_ctl(train_ctl), .link_pad(link_pad), .lane_pad(lane_pad),
    .ts1_cnt(ts1_cnt), .ts2_cnt(ts2_cnt), .ts1_done(ts1_done), .ts2_done(ts2_done),
    .os_err(os_err));

  typedef struct {
    logic is2; logic lpad; logic [7:0] link; logic npad; logic [7:0] lane;
  } ts_t;

  function automatic ts_t mk_ts(input logic is2, input logic lpad, input logic [7:0] link,
                                input logic npad, input logic [7:0] lane);
    ts_t t;
    t.is2 = is2; t.lpad = lpad; t.link = link; t.npad = npad; t.lane = lane;
    return t;
  endfunction

  // {k, data} of symbol i; n_fts = 0x10, rate_id = 0x02, train_ctl = 0x00
  function automatic logic [8:0] ts_sym(input ts_t t, input int i);
    case (i)
      0:       return {1'b1, 8'hBC};
      1:       return t.lpad ? {1'b1, 8'hF7} : {1'b0, t.link};
      2:       return t.npad ? {1'b1, 8'hF7} : {1'b0, t.lane};
      3:       return {1'b0, 8'h10};
      4:       return {1'b0, 8'h02};
      5:       return {1'b0, 8'h00};
      default: return {1'b0, t.is2 ? 8'h45 : 8'h4A};
    endcase
  endfunction

  task automatic send_sym(input logic [7:0] d, input logic k, input logic v, input logic ei);
    rxdata = d; rxdatak = k; rxvalid = v; rxelecidle = ei;
    @(posedge clk); #1;
    if (ts1_det) n_det1++;
    if (ts2_det) n_det2++;
    if (os_err) n_err++;
    if (os_err && (ts1_det || ts2_det)) n_both++;
  endtask

  task automatic send_ts(input ts_t t, input int first = 0, input int last = 15,
                         input int bad_idx = -1, input logic [8:0] bad_sym = '0,
                         input int gap_idx = -1, input int gap_len = 0, input int ei_idx = -1);
    logic [8:0] s;
    for (int i = first; i <= last; i++) begin
      if (i == gap_idx)
        for (int g = 0; g < gap_len; g++) send_sym(8'hBC, 1'b1, 1'b0, 1'b0);
      s = (i == bad_idx) ? bad_sym : ts_sym(t, i);
      send_sym(s[7:0], s[8], 1'b1, i == ei_idx);
    end
  endtask

  task automatic do_reset();
    rxvalid = 1'b0; rxelecidle = 1'b0; rxdata = '0; rxdatak = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n_det1 = 0; n_det2 = 0; n_err = 0; n_both = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({ts1_det, ts2_det, os_err, ts1_done, ts2_done, link_pad, lane_pad} !== 7'd0) begin n_bad++; $display("FAIL reset_flags got=%b want=0", {ts1_det, ts2_det, os_err, ts1_done, ts2_done, link_pad, lane_pad}); end
    n_cmp++; if ({link_num, lane_num, n_fts, rate_id, train_ctl} !== 40'd0) begin n_bad++; $display("FAIL reset_fields got=%h want=0", {link_num, lane_num, n_fts, rate_id, train_ctl}); end
    n_cmp++; if ({ts1_cnt, ts2_cnt} !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", ts1_cnt, ts2_cnt); end
  endtask

  task automatic test_ts1_train();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      send_ts(p);
      n_cmp++; if (ts1_det !== 1'b1) begin n_bad++; $display("FAIL train_det set=%0d got=%b want=1", k, ts1_det); end
      n_cmp++; if (ts1_cnt !== CNT_W'(k)) begin n_bad++; $display("FAIL train_cnt got=%0d want=%0d", ts1_cnt, k); end
      n_cmp++; if (ts1_done !== (k >= NTS)) begin n_bad++; $display("FAIL train_done set=%0d got=%b want=%b", k, ts1_done, k >= NTS); end
    end
    n_cmp++; if ({link_pad, lane_pad, link_num, n_fts, rate_id} !== {2'b11, 8'hF7, 8'h10, 8'h02}) begin n_bad++; $display("FAIL train_fields got=%b%b %h %h %h want=11 f7 10 02", link_pad, lane_pad, link_num, n_fts, rate_id); end
    send_sym(8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ts1_det !== 1'b0) begin n_bad++; $display("FAIL train_det_width got=%b want=0", ts1_det); end
    n_cmp++; if ({n_det1, n_det2, n_err} !== {32'd8, 32'd0, 32'd0}) begin n_bad++; $display("FAIL train_pulses got=%0d/%0d/%0d want=8/0/0", n_det1, n_det2, n_err); end
  endtask

  task automatic test_rxvalid_gap();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) send_ts(p, 0, 15, -1, '0, 9, 3);
      else send_ts(p);
      n_cmp++; if (ts1_cnt !== CNT_W'(k) || ts1_det !== 1'b1) begin n_bad++; $display("FAIL gap_cnt set=%0d got=%0d det=%b want=%0d det=1", k, ts1_cnt, ts1_det, k); end
    end
    n_cmp++; if ({n_det1, n_err} !== {32'd8, 32'd0} || ts1_done !== 1'b1) begin n_bad++; $display("FAIL gap_summary got=%0d/%0d done=%b want=8/0 done=1", n_det1, n_err, ts1_done); end
  endtask

  task automatic test_bad_id();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    ts_t q = mk_ts(1'b0, 1'b0, 8'h05, 1'b1, 8'h00);
    do_reset();
    send_ts(p); send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd2) begin n_bad++; $display("FAIL badid_pre got=%0d want=2", ts1_cnt); end
    send_ts(q, 0, 11, 11, {1'b0, 8'h45});
    n_cmp++; if (os_err !== 1'b1 || ts1_cnt !== 11'd0) begin n_bad++; $display("FAIL badid_err got=%b cnt=%0d want=1 cnt=0", os_err, ts1_cnt); end
    send_ts(q, 12, 15);
    n_cmp++; if ({n_err, n_det1} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL badid_hunt got=%0d/%0d want=1/2", n_err, n_det1); end
    n_cmp++; if ({link_num, link_pad} !== {8'hF7, 1'b1}) begin n_bad++; $display("FAIL badid_hold got=%h %b want=f7 1", link_num, link_pad); end
    send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd1 || ts1_det !== 1'b1) begin n_bad++; $display("FAIL badid_recover got=%0d det=%b want=1 det=1", ts1_cnt, ts1_det); end
  endtask

  task automatic test_field_change();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    ts_t q = mk_ts(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      send_ts(p);
      n_cmp++; if (ts1_cnt !== CNT_W'(k)) begin n_bad++; $display("FAIL fchg_cnt got=%0d want=%0d", ts1_cnt, k); end
    end
    send_ts(q);
    n_cmp++; if (ts1_cnt !== 11'd1) begin n_bad++; $display("FAIL fchg_reload got=%0d want=1", ts1_cnt); end
    n_cmp++; if ({link_num, link_pad, lane_pad} !== {8'h00, 1'b0, 1'b1}) begin n_bad++; $display("FAIL fchg_fields got=%h %b %b want=00 0 1", link_num, link_pad, lane_pad); end
  endtask

  task automatic test_ts1_to_ts2();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    ts_t r = mk_ts(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    do_reset();
    repeat (10) send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd10 || ts1_done !== 1'b1) begin n_bad++; $display("FAIL t2_ts1 got=%0d done=%b want=10 done=1", ts1_cnt, ts1_done); end
    send_ts(r);
    n_cmp++; if ({ts1_cnt, ts2_cnt} !== {11'd0, 11'd1} || ts1_done !== 1'b0) begin n_bad++; $display("FAIL t2_switch got=%0d/%0d done=%b want=0/1 done=0", ts1_cnt, ts2_cnt, ts1_done); end
    n_cmp++; if ({ts2_det, ts1_det} !== 2'b10) begin n_bad++; $display("FAIL t2_det got=%b%b want=10", ts2_det, ts1_det); end
    send_ts(r); send_ts(r);
    n_cmp++; if (ts2_cnt !== 11'd3 || ts2_done !== 1'b0) begin n_bad++; $display("FAIL t2_cnt got=%0d done=%b want=3 done=0", ts2_cnt, ts2_done); end
  endtask

  task automatic test_com_realign();
    ts_t r = mk_ts(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    send_ts(r, 0, 7, 7, {1'b1, 8'hBC});
    n_cmp++; if (os_err !== 1'b1 || ts2_cnt !== 11'd0) begin n_bad++; $display("FAIL realign_err got=%b cnt=%0d want=1 cnt=0", os_err, ts2_cnt); end
    send_ts(r, 1, 15);
    n_cmp++; if (ts2_det !== 1'b1 || ts2_cnt !== 11'd1) begin n_bad++; $display("FAIL realign_set got=%b cnt=%0d want=1 cnt=1", ts2_det, ts2_cnt); end
    n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL det_err_overlap got=%0d want=0", n_both); end
  endtask

  task automatic test_elecidle();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    int d0, e0;
    do_reset();
    repeat (8) send_ts(p);
    send_ts(p, 0, 7);
    send_sym(8'h4A, 1'b0, 1'b1, 1'b1);
    n_cmp++; if ({ts1_cnt, ts1_done, os_err} !== {11'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL eidle_clr got=%0d done=%b err=%b want=0 0 0", ts1_cnt, ts1_done, os_err); end
    d0 = n_det1; e0 = n_err;
    send_ts(p, 8, 15);
    n_cmp++; if (n_det1 !== d0 || n_err !== e0) begin n_bad++; $display("FAIL eidle_hunt got=%0d/%0d want=%0d/%0d", n_det1, n_err, d0, e0); end
    send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd1) begin n_bad++; $display("FAIL eidle_recover got=%0d want=1", ts1_cnt); end
    d0 = n_det1;
    send_ts(p, 0, 15, -1, '0, -1, 0, 15);
    n_cmp++; if (n_det1 !== d0 || ts1_cnt !== 11'd0) begin n_bad++; $display("FAIL eidle_last got=%0d cnt=%0d want=%0d cnt=0", n_det1, ts1_cnt, d0); end
    n_cmp++; if (link_num !== 8'hF7) begin n_bad++; $display("FAIL eidle_hold got=%h want=f7", link_num); end
  endtask

  task automatic test_reset_mid();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    int d0;
    do_reset();
    send_ts(p); send_ts(p); send_ts(p, 0, 4);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({ts1_cnt, link_num, n_fts, link_pad, lane_pad, ts1_det} !== '0) begin n_bad++; $display("FAIL rstmid_async got=%0d %h %h %b%b%b want=0", ts1_cnt, link_num, n_fts, link_pad, lane_pad, ts1_det); end
    @(posedge clk); #1 reset_n = 1'b1;
    d0 = n_det1;
    send_ts(p, 5, 15);
    n_cmp++; if (n_det1 !== d0) begin n_bad++; $display("FAIL rstmid_nodet got=%0d want=%0d", n_det1, d0); end
    send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd1) begin n_bad++; $display("FAIL rstmid_recover got=%0d want=1", ts1_cnt); end
  endtask

  task automatic test_saturate();
    ts_t p = mk_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    do_reset();
    repeat (2047) send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd2047) begin n_bad++; $display("FAIL sat_max got=%0d want=2047", ts1_cnt); end
    send_ts(p);
    n_cmp++; if (ts1_cnt !== 11'd2047 || ts1_done !== 1'b1) begin n_bad++; $display("FAIL sat_hold got=%0d done=%b want=2047 done=1", ts1_cnt, ts1_done); end
  endtask

  initial begin
    test_reset();
    test_ts1_train();
    test_rxvalid_gap();
    test_bad_id();
    test_field_change();
    test_ts1_to_ts2();
    test_com_realign();
    test_elecidle();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
